mont_exp_precompute: RTL



---
 rtl/mont_exp_precompute.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mont_exp_precompute.sv
// Montgomery operand preparation: derives R mod m and R^2 mod m (R = 2^WORD_WIDTH)
// by shift-and-conditional-subtract, plus the MSB index of the exponent.
module mont_exp_precompute #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [WORD_WIDTH-1:0]         m,
    input  logic [WORD_WIDTH-1:0]         e,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          e_zero,
    output logic [WORD_WIDTH-1:0]         r_mod_m,
    output logic [WORD_WIDTH-1:0]         r2_mod_m,
    output logic [$clog2(WORD_WIDTH)-1:0] t
);

    localparam int TW = $clog2(WORD_WIDTH);
    localparam int KW = $clog2(2 * WORD_WIDTH);
    localparam logic [KW-1:0] K_WORD = KW'(WORD_WIDTH);
    localparam logic [KW-1:0] K_HALF = KW'(WORD_WIDTH - 1);
    localparam logic [KW-1:0] K_LAST = KW'(2 * WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_LOOP,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] m_q, m_d;
    logic [WORD_WIDTH-1:0] e_q, e_d;
    logic [WORD_WIDTH-1:0] v_q, v_d;
    logic [KW-1:0]         k_q, k_d;
    logic [TW-1:0]         t_acc_q, t_acc_d;
    logic                  err_q, err_d;
    logic                  e_zero_q, e_zero_d;
    logic [WORD_WIDTH-1:0] r_q, r_d;
    logic [WORD_WIDTH-1:0] r2_q, r2_d;
    logic [TW-1:0]         t_q, t_d;

    logic [WORD_WIDTH:0]   v2;
    logic [WORD_WIDTH:0]   m_ext;
    logic [WORD_WIDTH-1:0] v_next;

    // v < m and m odd keep 2v - m below m, so a single subtract suffices.
    always_comb begin
        v2     = {v_q, 1'b0};
        m_ext  = {1'b0, m_q};
        v_next = WORD_WIDTH'((v2 >= m_ext) ? (v2 - m_ext) : v2);
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        e_d      = e_q;
        v_d      = v_q;
        k_d      = k_q;
        t_acc_d  = t_acc_q;
        err_d    = err_q;
        e_zero_d = e_zero_q;
        r_d      = r_q;
        r2_d     = r2_q;
        t_d      = t_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    m_d     = m;
                    e_d     = e;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                err_d    = 1'b0;
                e_zero_d = 1'b0;
                r_d      = '0;
                r2_d     = '0;
                t_d      = '0;
                if (!m_q[0] || (m_q == WORD_WIDTH'(1))) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    v_d     = WORD_WIDTH'(1);
                    k_d     = '0;
                    t_acc_d = '0;
                    state_d = S_LOOP;
                end
            end
            S_LOOP: begin
                v_d = v_next;
                if ((k_q < K_WORD) && e_q[k_q[TW-1:0]]) begin
                    t_acc_d = k_q[TW-1:0];
                end
                if (k_q == K_HALF) begin
                    r_d = v_next;
                end
                if (k_q == K_LAST) begin
                    r2_d     = v_next;
                    t_d      = t_acc_d;
                    e_zero_d = (e_q == '0);
                    state_d  = S_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            e_q      <= '0;
            v_q      <= '0;
            k_q      <= '0;
            t_acc_q  <= '0;
            err_q    <= 1'b0;
            e_zero_q <= 1'b0;
            r_q      <= '0;
            r2_q     <= '0;
            t_q      <= '0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            e_q      <= e_d;
            v_q      <= v_d;
            k_q      <= k_d;
            t_acc_q  <= t_acc_d;
            err_q    <= err_d;
            e_zero_q <= e_zero_d;
            r_q      <= r_d;
            r2_q     <= r2_d;
            t_q      <= t_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign e_zero   = e_zero_q;
    assign r_mod_m  = r_q;
    assign r2_mod_m = r2_q;
    assign t        = t_q;

endmodule
